// File: rtl/dc_useq.sv
// dc_useq: banked microsequencer with next-address selection and one-hot bank select.
// Optional call/return stack and sticky error flag enabled by defining DC_USEQ_STACK_EN.
module dc_useq #(
    parameter int AW = 9,
    parameter int MW = 16,
    parameter int NB = 3,
    parameter int SD = 4
) (
    input  logic          pin_clk,
    input  logic          pin_rst,
    input  logic          pin_mce_p,
    input  logic          pin_mce_n,
    input  logic          pin_bra,
    input  logic [AW-1:0] rom_ma,
    input  logic [MW-1:0] rom_mc,
    output logic [AW-1:0] rom_a,
    output logic [NB-1:0] rom_bank,
    output logic [MW-1:0] pin_m,
    output logic          pin_cs,
    output logic          pin_rni,
    output logic          pin_err
);

    localparam logic [4:0] OP_JMP  = 5'd0;
    localparam logic [4:0] OP_CJMP = 5'd1;

    if (AW < 8 || AW > 12 || MW < 16 || NB < 1 || NB > 8 || SD < 1 || SD > 16) begin : g_param_check
        $error("dc_useq: parameter out of legal range");
    end

    logic [MW-1:0] mi_q;
    logic [AW-1:0] nar_q;
    logic [AW-1:0] rom_a_q;
    logic [NB-1:0] bank_q;
    logic [AW-1:0] na_d;
    logic [NB-1:0] bank_d;
    logic [4:0]    op;
    logic [4:0]    bsel;

    assign op   = mi_q[15:11];
    assign bsel = mi_q[10:6];

`ifdef DC_USEQ_STACK_EN
    localparam logic [4:0] OP_CALL = 5'd2;
    localparam logic [4:0] OP_RET  = 5'd3;
    localparam int SPW   = $clog2(SD + 1);
    localparam int IW    = (SD > 1) ? $clog2(SD) : 1;
    localparam int DEPTH = 1 << IW;

    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;
    logic           err_q;
    logic           err_d;
    logic           push;
    logic [IW-1:0]  wr_idx;
    logic [IW-1:0]  top_idx;
    logic [AW-1:0]  stk_addr_q [DEPTH];
    logic [NB-1:0]  stk_bank_q [DEPTH];

    assign wr_idx  = IW'(sp_q);
    assign top_idx = IW'(sp_q - SPW'(1));
`endif

    always_comb begin
        na_d   = nar_q;
        bank_d = bank_q;
`ifdef DC_USEQ_STACK_EN
        sp_d   = sp_q;
        err_d  = err_q;
        push   = 1'b0;
`endif
        case (op)
            OP_JMP: begin
                na_d   = AW'(mi_q[5:0]);
                bank_d = (int'(bsel) < NB) ? (NB'(1) << bsel) : '0;
            end
            OP_CJMP: begin
                // Taken branch keeps the current 256-word page of the ROM next address.
                if (!pin_bra) begin
                    na_d = (nar_q & ~AW'(8'hFF)) | AW'(mi_q[7:0]);
                end
            end
`ifdef DC_USEQ_STACK_EN
            OP_CALL: begin
                na_d = AW'(mi_q[7:0]);
                if (sp_q == SPW'(SD)) begin
                    err_d = 1'b1;
                end else begin
                    push = 1'b1;
                    sp_d = sp_q + SPW'(1);
                end
            end
            OP_RET: begin
                if (sp_q == '0) begin
                    err_d  = 1'b1;
                    na_d   = '0;
                    bank_d = NB'(1);
                end else begin
                    na_d   = stk_addr_q[top_idx];
                    bank_d = stk_bank_q[top_idx];
                    sp_d   = sp_q - SPW'(1);
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge pin_clk or posedge pin_rst) begin
        if (pin_rst) begin
            mi_q    <= '0;
            nar_q   <= '0;
            rom_a_q <= '0;
            bank_q  <= NB'(1);
        end else begin
            if (pin_mce_n) begin
                mi_q  <= rom_mc;
                nar_q <= rom_ma;
            end
            if (pin_mce_p) begin
                rom_a_q <= na_d;
                bank_q  <= bank_d;
            end
        end
    end

`ifdef DC_USEQ_STACK_EN
    always_ff @(posedge pin_clk or posedge pin_rst) begin
        if (pin_rst) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else if (pin_mce_p) begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack contents need no reset; the pointer alone defines validity.
    always_ff @(posedge pin_clk) begin
        if (pin_mce_p && push) begin
            stk_addr_q[wr_idx] <= nar_q;
            stk_bank_q[wr_idx] <= bank_q;
        end
    end

    assign pin_err = err_q;
`else
    assign pin_err = 1'b0;
`endif

    assign rom_a    = rom_a_q;
    assign rom_bank = bank_q;
    assign pin_m    = mi_q;
    assign pin_cs   = |bank_q;
    assign pin_rni  = (rom_a_q == '0) && pin_cs;

endmodule
